// File: rtl/moonbase_nbus_ctrl.sv
`default_nettype none
// ============================================================================
// moonbase_nbus_ctrl : nibble-serial external bus sequencer (address, IO and
//                      data beats, wait stretching with timeout, req/rsp)
// Revision: 1.0
// ============================================================================
module moonbase_nbus_ctrl #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 12,
    parameter int NIB_W    = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_io,
    input  logic [NIB_W:0]    req_io_code,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [NIB_W-1:0]  rsp_io_status,
    output logic [NIB_W+3:0]  bus_out,
    output logic              bus_cyc,
    input  logic [NIB_W-1:0]  bus_in,
    input  logic              bus_wait
);
    localparam int CHUNK_W    = NIB_W + 2;
    localparam int ADDR_BEATS = (ADDR_W + CHUNK_W - 1) / CHUNK_W;
    localparam int DATA_BEATS = (DATA_W + NIB_W - 1) / NIB_W;
    localparam int ADDR_PAD   = ADDR_BEATS * CHUNK_W;
    localparam int DATA_PAD   = DATA_BEATS * NIB_W;
    localparam int MAX_BEATS  = (ADDR_BEATS > DATA_BEATS) ? ADDR_BEATS : DATA_BEATS;
    localparam int BEAT_W     = $clog2(MAX_BEATS) + 1;
    localparam int WAIT_W     = $clog2(MAX_WAIT + 1);

    localparam logic [BEAT_W-1:0] ADDR_LAST = BEAT_W'(ADDR_BEATS - 1);
    localparam logic [BEAT_W-1:0] DATA_LAST = BEAT_W'(DATA_BEATS - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_IO   = 2'd2;
    localparam logic [1:0] ST_DATA = 2'd3;

    // A single-beat data phase would make first&last collide with the IO code.
    generate
        if (DATA_BEATS < 2) begin : g_data_beats_check
            $error("moonbase_nbus_ctrl: DATA_W/NIB_W must give at least 2 data beats");
        end
    endgenerate

    logic [1:0]              state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [WAIT_W-1:0]       wait_q, wait_d;
    logic [ADDR_PAD-1:0]     addr_sh_q, addr_sh_d;
    logic [DATA_PAD-1:0]     wdata_sh_q, wdata_sh_d;
    logic [DATA_PAD-NIB_W-1:0] rdata_sh_q, rdata_sh_d;
    logic                    write_q, write_d;
    logic                    io_q, io_d;
    logic [NIB_W:0]          io_code_q, io_code_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;
    logic [NIB_W-1:0]        rsp_io_status_q, rsp_io_status_d;
    logic [DATA_PAD-1:0]     w_rdata_next;

    assign w_rdata_next = {rdata_sh_q, bus_in};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            beat_q          <= '0;
            wait_q          <= '0;
            addr_sh_q       <= '0;
            wdata_sh_q      <= '0;
            rdata_sh_q      <= '0;
            write_q         <= 1'b0;
            io_q            <= 1'b0;
            io_code_q       <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_err_q       <= 1'b0;
            rsp_rdata_q     <= '0;
            rsp_io_status_q <= '0;
        end else begin
            state_q         <= state_d;
            beat_q          <= beat_d;
            wait_q          <= wait_d;
            addr_sh_q       <= addr_sh_d;
            wdata_sh_q      <= wdata_sh_d;
            rdata_sh_q      <= rdata_sh_d;
            write_q         <= write_d;
            io_q            <= io_d;
            io_code_q       <= io_code_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_err_q       <= rsp_err_d;
            rsp_rdata_q     <= rsp_rdata_d;
            rsp_io_status_q <= rsp_io_status_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        beat_d          = beat_q;
        wait_d          = wait_q;
        addr_sh_d       = addr_sh_q;
        wdata_sh_d      = wdata_sh_q;
        rdata_sh_d      = rdata_sh_q;
        write_d         = write_q;
        io_d            = io_q;
        io_code_d       = io_code_q;
        rsp_valid_d     = 1'b0;
        rsp_err_d       = 1'b0;
        rsp_rdata_d     = rsp_rdata_q;
        rsp_io_status_d = rsp_io_status_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d    = ST_ADDR;
                    beat_d     = '0;
                    wait_d     = '0;
                    addr_sh_d  = ADDR_PAD'(req_addr);
                    wdata_sh_d = DATA_PAD'(req_wdata);
                    rdata_sh_d = '0;
                    write_d    = req_write;
                    io_d       = req_io;
                    io_code_d  = req_io_code;
                end
            end
            ST_ADDR: begin
                addr_sh_d = addr_sh_q << CHUNK_W;
                if (beat_q == ADDR_LAST) begin
                    beat_d  = '0;
                    state_d = io_q ? ST_IO : ST_DATA;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            ST_IO: begin
                rsp_io_status_d = bus_in;
                state_d         = ST_DATA;
            end
            default: begin
                // Data beat: a held wait repeats the beat; MAX_WAIT+1 waits abort.
                if (bus_wait) begin
                    if (wait_q == WAIT_MAX) begin
                        state_d     = ST_IDLE;
                        wait_d      = '0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end else begin
                    wait_d     = '0;
                    rdata_sh_d = w_rdata_next[DATA_PAD-NIB_W-1:0];
                    wdata_sh_d = wdata_sh_q << NIB_W;
                    if (beat_q == DATA_LAST) begin
                        state_d     = ST_IDLE;
                        beat_d      = '0;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = write_q ? '0 : w_rdata_next[DATA_W-1:0];
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        bus_cyc   = 1'b0;
        bus_out   = '0;
        case (state_q)
            ST_IDLE: req_ready = 1'b1;
            ST_ADDR: begin
                bus_cyc = 1'b1;
                bus_out = {1'b1, (beat_q == ADDR_LAST), addr_sh_q[ADDR_PAD-1 -: CHUNK_W]};
            end
            ST_IO: begin
                bus_cyc = 1'b1;
                bus_out = {3'b011, io_code_q};
            end
            default: begin
                bus_cyc = 1'b1;
                bus_out = {1'b0, (beat_q == DATA_LAST), (beat_q == '0), write_q,
                           write_q ? wdata_sh_q[DATA_PAD-1 -: NIB_W] : {NIB_W{1'b0}}};
            end
        endcase
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_err       = rsp_err_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_io_status = rsp_io_status_q;

endmodule
`default_nettype wire

// File: tb/tb_moonbase_nbus_ctrl.sv
`default_nettype none
// ============================================================================
// tb_moonbase_nbus_ctrl : randomized bench for moonbase_nbus_ctrl, default
//                         12/12 instance and a 16/16 instance
// Revision: 1.0
// ============================================================================
module tb_moonbase_nbus_ctrl;
    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sel;
    logic        req_valid, req_write, req_io;
    logic [4:0]  req_io_code;
    logic [15:0] req_addr, req_wdata;
    logic [3:0]  bus_in;
    logic        bus_wait;

    logic        a_ready, a_rsp_valid, a_rsp_err, a_cyc;
    logic [11:0] a_rdata;
    logic [3:0]  a_io;
    logic [7:0]  a_bus_out;
    logic        b_ready, b_rsp_valid, b_rsp_err, b_cyc;
    logic [15:0] b_rdata;
    logic [3:0]  b_io;
    logic [7:0]  b_bus_out;

    logic        w_ready, w_rsp_valid, w_rsp_err, w_cyc;
    logic [15:0] w_rdata;
    logic [3:0]  w_io;
    logic [7:0]  w_bus_out;

    int n_total = 0;
    int n_bad   = 0;
    int aw, dw;
    int exp_io, last_rd;

    always #5 clk = ~clk;

    moonbase_nbus_ctrl u_dut_a (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid & ~sel), .req_ready(a_ready),
        .req_write(req_write), .req_io(req_io), .req_io_code(req_io_code),
        .req_addr(req_addr[11:0]), .req_wdata(req_wdata[11:0]),
        .rsp_valid(a_rsp_valid), .rsp_err(a_rsp_err), .rsp_rdata(a_rdata),
        .rsp_io_status(a_io), .bus_out(a_bus_out), .bus_cyc(a_cyc),
        .bus_in(bus_in), .bus_wait(bus_wait)
    );

    moonbase_nbus_ctrl #(.ADDR_W(16), .DATA_W(16)) u_dut_b (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid & sel), .req_ready(b_ready),
        .req_write(req_write), .req_io(req_io), .req_io_code(req_io_code),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_err(b_rsp_err), .rsp_rdata(b_rdata),
        .rsp_io_status(b_io), .bus_out(b_bus_out), .bus_cyc(b_cyc),
        .bus_in(bus_in), .bus_wait(bus_wait)
    );

    assign w_ready     = sel ? b_ready     : a_ready;
    assign w_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign w_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
    assign w_cyc       = sel ? b_cyc       : a_cyc;
    assign w_rdata     = sel ? b_rdata     : {4'h0, a_rdata};
    assign w_io        = sel ? b_io        : a_io;
    assign w_bus_out   = sel ? b_bus_out   : a_bus_out;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s (dut%0d, t=%0t): got 0x%0h expected 0x%0h", tag, sel, $time, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_ready"},  32'(w_ready), 1);
        check_eq({tag, "_rspv"},   32'(w_rsp_valid), 0);
        check_eq({tag, "_err"},    32'(w_rsp_err), 0);
        check_eq({tag, "_rdata"},  32'(w_rdata), 0);
        check_eq({tag, "_io"},     32'(w_io), 0);
        check_eq({tag, "_busout"}, 32'(w_bus_out), 0);
        check_eq({tag, "_cyc"},    32'(w_cyc), 0);
    endtask

    // wmode: 0 no waits, 1 random waits, 2 wait forever (timeout), 3 three waits on data beat 1
    task automatic run_txn(input bit wr, input bit io, input logic [4:0] code,
                           input logic [15:0] addr, input logic [15:0] wdata,
                           input int wmode, input bit hold, input bit mid_reset);
        logic [7:0] beats[$];
        int ab, db, am, wm, b, nib, idx, wc, cyc, rd, dbi, exp_rd;
        bit done, abort, is_data, w;
        ab = (aw + 5) / 6;
        db = (dw + 3) / 4;
        am = int'(addr) & ((1 << aw) - 1);
        wm = int'(wdata) & ((1 << dw) - 1);
        for (int i = 0; i < ab; i++) begin
            b = 'h80 | ((i == ab - 1) ? 'h40 : 0) | ((am >> (6 * (ab - 1 - i))) & 63);
            beats.push_back(b[7:0]);
        end
        if (io) begin
            b = 'h60 | int'(code);
            beats.push_back(b[7:0]);
        end
        for (int i = 0; i < db; i++) begin
            nib = wr ? ((wm >> (4 * (db - 1 - i))) & 15) : 0;
            b = ((i == db - 1) ? 'h40 : 0) | ((i == 0) ? 'h20 : 0) | (wr ? 'h10 : 0) | nib;
            beats.push_back(b[7:0]);
        end

        check_eq("rdata_hold", 32'(w_rdata), last_rd);
        check_eq("io_hold", 32'(w_io), exp_io);
        req_write = wr; req_io = io; req_io_code = code; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        check_eq("accept_ready", 32'(w_ready), 1);
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;

        idx = 0; wc = 0; cyc = 0; rd = 0; done = 0; abort = 0;
        while (!done && !abort && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (mid_reset && cyc == ab + int'(io) + 2) begin
                bus_wait = 1'b0;
                reset_n  = 1'b0;
                #1;
                check_reset("mid_rst");
                exp_io = 0; last_rd = 0;
                #1 reset_n = 1'b1;
                repeat (2) begin
                    @(negedge clk);
                    check_eq("no_rsp_after_rst", 32'(w_rsp_valid), 0);
                    check_eq("idle_after_rst", 32'(w_cyc), 0);
                end
                return;
            end
            check_eq($sformatf("beat%0d", idx), 32'(w_bus_out), 32'(beats[idx]));
            check_eq("beat_cyc", 32'(w_cyc), 1);
            check_eq("beat_rspv", 32'(w_rsp_valid), 0);
            check_eq("beat_ready", 32'(w_ready), 0);

            is_data = (idx >= ab + int'(io));
            dbi = idx - ab - int'(io);
            case (wmode)
                1:       w = ($urandom_range(0, 3) == 0);
                2:       w = is_data;
                3:       w = is_data && dbi == 1 && wc < 3;
                default: w = 1'b0;
            endcase
            bus_wait = w;
            bus_in   = 4'($urandom_range(0, 15));

            if (is_data && w) begin
                if (wc == MAX_WAIT) abort = 1;
                else wc++;
            end else begin
                if (is_data && !wr) rd = (rd << 4) | int'(bus_in);
                if (io && idx == ab) exp_io = int'(bus_in);
                idx++;
                wc = 0;
                if (idx == beats.size()) done = 1;
            end
        end
        check_eq("txn_finished", 32'(done | abort), 1);

        @(negedge clk);
        bus_wait = 1'b0;
        exp_rd = (abort || wr) ? 0 : (rd & ((1 << dw) - 1));
        check_eq("rsp_valid", 32'(w_rsp_valid), 1);
        check_eq("rsp_err", 32'(w_rsp_err), 32'(abort));
        check_eq("rsp_rdata", 32'(w_rdata), exp_rd);
        check_eq("rsp_io", 32'(w_io), exp_io);
        check_eq("rsp_cyc", 32'(w_cyc), 0);
        check_eq("rsp_busout", 32'(w_bus_out), 0);
        check_eq("rsp_ready", 32'(w_ready), 1);
        last_rd = exp_rd;
    endtask

    task automatic run_suite();
        run_txn(0, 0, 5'h00, 16'h0ABC, 16'h0000, 0, 0, 0);
        repeat (2) @(negedge clk);
        run_txn(1, 1, 5'h12, 16'h0041, 16'h05A5, 0, 0, 0);
        run_txn(0, 0, 5'h00, 16'h0ABC, 16'h0000, 3, 0, 0);
        @(negedge clk);
        run_txn(0, 1, 5'h05, 16'h0123, 16'h0000, 2, 0, 0);
        @(negedge clk);
        check_eq("post_abort_cyc", 32'(w_cyc), 0);
        run_txn(0, 0, 5'h00, 16'h0321, 16'h0000, 0, 1, 0);
        run_txn(0, 0, 5'h00, 16'hBEEF, 16'h0000, 0, 0, 0);
        @(negedge clk);
        run_txn(1, 0, 5'h00, 16'h0777, 16'h0F0F, 0, 0, 1);
        run_txn(0, 1, 5'h1F, 16'h0456, 16'h0000, 0, 0, 0);
        for (int k = 0; k < 25; k++) begin
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 31)), 16'($urandom), 16'($urandom),
                    1, 1'($urandom_range(0, 1)), 0);
            if (!req_valid) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_io = 1'b0;
        req_io_code = '0; req_addr = '0; req_wdata = '0; bus_in = '0; bus_wait = 1'b0;
        aw = 12; dw = 12; exp_io = 0; last_rd = 0;
        repeat (3) @(negedge clk);
        check_reset("por");
        reset_n = 1'b1;
        @(negedge clk);
        check_reset("post_release");
        run_suite();

        sel = 1'b1; aw = 16; dw = 16;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        exp_io = 0; last_rd = 0;
        @(negedge clk);
        check_reset("wide_reset");
        run_suite();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, got t=%0t expected < 2000000", $time);
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
